pll_sequencer: RTL and testbench

PLL_SEQUENCER -- requirements
Module: pll_sequencer

---
 rtl/pll_sequencer.sv | 171 +++++++++++++++++
 tb/tb_pll_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_sequencer.sv
// PLL power-up sequencer: holds the PLL in reset, qualifies a stable lock with
// timeout and retry, then releases the downstream reset; FAULT after retries.
module pll_sequencer #(
    parameter int unsigned RESET_HOLD_CYCLES   = 12,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1200,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 12000,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_resetb,
    output logic       sys_reset_n,
    output logic       ready,
    output logic       fault,
    output logic       lock_lost,
    output logic [3:0] retry_count
);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    localparam logic [15:0] HOLD_LAST  = 16'(RESET_HOLD_CYCLES - 1);
    localparam logic [15:0] STAB_LAST  = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [15:0] TMO_LAST   = 16'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [15:0] RETRY_MAX  = 16'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] tmo_q, tmo_d;
    logic [15:0] stab_q, stab_d;
    logic [3:0]  retry_q, retry_d;
    logic        sync1_q, sync2_q;
    logic        pll_resetb_q, pll_resetb_d;
    logic        sys_reset_n_q, sys_reset_n_d;
    logic        ready_q, ready_d;
    logic        fault_q, fault_d;
    logic        lock_lost_q, lock_lost_d;
    logic        lock_s;
    logic        retry_ok_s;
    logic [3:0]  retry_inc_s;

    assign lock_s      = sync2_q;
    assign retry_ok_s  = ({12'd0, retry_q} < RETRY_MAX);
    assign retry_inc_s = (retry_q == 4'd15) ? 4'd15 : (retry_q + 4'd1);

    // Next-state, counter and output decode; outputs follow the next state so
    // the registered outputs always match the registered state.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        tmo_d       = tmo_q;
        stab_d      = stab_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;
        if (restart) begin
            state_d = PLL_RST;
            hold_d  = 16'd0;
            tmo_d   = 16'd0;
            stab_d  = 16'd0;
            retry_d = 4'd0;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = WAIT_LOCK;
                        hold_d  = 16'd0;
                        tmo_d   = 16'd0;
                    end else begin
                        hold_d = hold_q + 16'd1;
                    end
                end
                WAIT_LOCK: begin
                    if (tmo_q == TMO_LAST) begin
                        state_d = retry_ok_s ? PLL_RST : FAULT;
                        retry_d = retry_ok_s ? retry_inc_s : retry_q;
                        hold_d  = 16'd0;
                    end else if (lock_s) begin
                        tmo_d   = tmo_q + 16'd1;
                        state_d = STABLE;
                        stab_d  = 16'd0;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
                end
                STABLE: begin
                    // a completed stable window wins over a same-cycle timeout
                    if (lock_s && (stab_q == STAB_LAST)) begin
                        state_d = RUN;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = retry_ok_s ? PLL_RST : FAULT;
                        retry_d = retry_ok_s ? retry_inc_s : retry_q;
                        hold_d  = 16'd0;
                    end else if (lock_s) begin
                        tmo_d  = tmo_q + 16'd1;
                        stab_d = stab_q + 16'd1;
                    end else begin
                        tmo_d   = tmo_q + 16'd1;
                        stab_d  = 16'd0;
                        state_d = WAIT_LOCK;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_d     = PLL_RST;
                        hold_d      = 16'd0;
                        lock_lost_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = PLL_RST;
                    hold_d  = 16'd0;
                end
            endcase
        end
        pll_resetb_d  = (state_d == WAIT_LOCK) || (state_d == STABLE) || (state_d == RUN);
        sys_reset_n_d = (state_d == RUN);
        ready_d       = (state_d == RUN);
        fault_d       = (state_d == FAULT);
    end

    // State, counters, lock synchronizer and registered outputs.
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            state_q       <= PLL_RST;
            hold_q        <= 16'd0;
            tmo_q         <= 16'd0;
            stab_q        <= 16'd0;
            retry_q       <= 4'd0;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            pll_resetb_q  <= 1'b0;
            sys_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
            lock_lost_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            tmo_q         <= tmo_d;
            stab_q        <= stab_d;
            retry_q       <= retry_d;
            sync1_q       <= pll_locked;
            sync2_q       <= sync1_q;
            pll_resetb_q  <= pll_resetb_d;
            sys_reset_n_q <= sys_reset_n_d;
            ready_q       <= ready_d;
            fault_q       <= fault_d;
            lock_lost_q   <= lock_lost_d;
        end
    end

    assign pll_resetb  = pll_resetb_q;
    assign sys_reset_n = sys_reset_n_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign lock_lost   = lock_lost_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_sequencer.sv
// Directed bench for pll_sequencer with HOLD=4, STABLE=8, TIMEOUT=32, RETRIES=2.
// Output vector order: {pll_resetb, sys_reset_n, ready, fault, lock_lost, retry_count}.
module tb_pll_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       restart;
    logic       pll_resetb;
    logic       sys_reset_n;
    logic       ready;
    logic       fault;
    logic       lock_lost;
    logic [3:0] retry_count;
    logic [8:0] outs;
    int         vectors = 0;
    int         miscompares = 0;

    pll_sequencer #(
        .RESET_HOLD_CYCLES  (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(32),
        .MAX_RETRIES        (2)
    ) dut (
        .clock_in   (clk),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_resetb (pll_resetb),
        .sys_reset_n(sys_reset_n),
        .ready      (ready),
        .fault      (fault),
        .lock_lost  (lock_lost),
        .retry_count(retry_count)
    );

    always #5 clk = ~clk;

    assign outs = {pll_resetb, sys_reset_n, ready, fault, lock_lost, retry_count};

    // advance n rising edges and settle just past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // after this, the next rising edge is the first one with reset released (E1)
    task automatic do_reset();
        reset_n = 1'b0;
        restart = 1'b0;
        step(2);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] exp_v;
        pll_locked = 1'b1;
        do_reset();
        exp_v = 9'b0_0_0_0_0_0000; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL reset_state: got %b want %b", outs, exp_v); end
    endtask

    task automatic test_nominal();
        logic [8:0] exp_v;
        step(3);
        exp_v = 9'b0_0_0_0_0_0000; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL nom_hold_e3: got %b want %b", outs, exp_v); end
        step(1);
        exp_v = 9'b1_0_0_0_0_0000; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL nom_resetb_e4: got %b want %b", outs, exp_v); end
        step(8);
        exp_v = 9'b1_0_0_0_0_0000; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL nom_stable_e12: got %b want %b", outs, exp_v); end
        step(1);
        exp_v = 9'b1_1_1_0_0_0000; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL nom_run_e13: got %b want %b", outs, exp_v); end
    endtask

    task automatic test_glitch();
        logic [8:0] exp_v;
        pll_locked = 1'b1;
        do_reset();
        step(6);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(6);
        exp_v = 9'b1_0_0_0_0_0000; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL glitch_e13: got %b want %b", outs, exp_v); end
        step(4);
        exp_v = 9'b1_0_0_0_0_0000; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL glitch_e17: got %b want %b", outs, exp_v); end
        step(1);
        exp_v = 9'b1_1_1_0_0_0000; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL glitch_run_e18: got %b want %b", outs, exp_v); end
    endtask

    // lock reaches STABLE at E28 so the 8th stable cycle coincides with timeout at E36
    task automatic test_stable_vs_timeout();
        logic [8:0] exp_v;
        pll_locked = 1'b0;
        do_reset();
        step(25);
        pll_locked = 1'b1;
        step(10);
        exp_v = 9'b1_0_0_0_0_0000; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL simul_e35: got %b want %b", outs, exp_v); end
        step(1);
        exp_v = 9'b1_1_1_0_0_0000; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL simul_run_e36: got %b want %b", outs, exp_v); end
    endtask

    task automatic test_lock_loss();
        logic [8:0] exp_v;
        pll_locked = 1'b0;
        do_reset();
        step(36);
        exp_v = 9'b0_0_0_0_0_0001; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL ll_retry1_e36: got %b want %b", outs, exp_v); end
        pll_locked = 1'b1;
        step(12);
        exp_v = 9'b1_0_0_0_0_0001; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL ll_e48: got %b want %b", outs, exp_v); end
        step(1);
        exp_v = 9'b1_1_1_0_0_0001; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL ll_run_e49: got %b want %b", outs, exp_v); end
        step(2);
        pll_locked = 1'b0;
        step(2);
        exp_v = 9'b1_1_1_0_0_0001; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL ll_still_run_e53: got %b want %b", outs, exp_v); end
        step(1);
        exp_v = 9'b0_0_0_0_1_0001; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL ll_pulse_e54: got %b want %b", outs, exp_v); end
        pll_locked = 1'b1;
        step(1);
        exp_v = 9'b0_0_0_0_0_0001; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL ll_pulse_end_e55: got %b want %b", outs, exp_v); end
        step(11);
        exp_v = 9'b1_0_0_0_0_0001; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL ll_rerun_e66: got %b want %b", outs, exp_v); end
        step(1);
        exp_v = 9'b1_1_1_0_0_0001; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL ll_rerun_run_e67: got %b want %b", outs, exp_v); end
    endtask

    // continues from RUN with retry_count=1: lock loss and restart land on the same edge
    task automatic test_restart_vs_lock_loss();
        logic [8:0] exp_v;
        pll_locked = 1'b0;
        step(2);
        exp_v = 9'b1_1_1_0_0_0001; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL rl_before: got %b want %b", outs, exp_v); end
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        exp_v = 9'b0_0_0_0_0_0000; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL rl_restart: got %b want %b", outs, exp_v); end
        step(1);
        exp_v = 9'b0_0_0_0_0_0000; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL rl_no_pulse: got %b want %b", outs, exp_v); end
    endtask

    task automatic test_never_lock();
        logic [8:0] exp_v;
        pll_locked = 1'b0;
        do_reset();
        step(35);
        exp_v = 9'b1_0_0_0_0_0000; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL nl_e35: got %b want %b", outs, exp_v); end
        step(1);
        exp_v = 9'b0_0_0_0_0_0001; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL nl_retry1_e36: got %b want %b", outs, exp_v); end
        step(3);
        exp_v = 9'b0_0_0_0_0_0001; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL nl_hold_e39: got %b want %b", outs, exp_v); end
        step(1);
        exp_v = 9'b1_0_0_0_0_0001; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL nl_release_e40: got %b want %b", outs, exp_v); end
        step(32);
        exp_v = 9'b0_0_0_0_0_0010; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL nl_retry2_e72: got %b want %b", outs, exp_v); end
        step(4);
        exp_v = 9'b1_0_0_0_0_0010; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL nl_release_e76: got %b want %b", outs, exp_v); end
        step(31);
        exp_v = 9'b1_0_0_0_0_0010; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL nl_e107: got %b want %b", outs, exp_v); end
        step(1);
        exp_v = 9'b0_0_0_1_0_0010; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL nl_fault_e108: got %b want %b", outs, exp_v); end
        step(20);
        exp_v = 9'b0_0_0_1_0_0010; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL nl_fault_held: got %b want %b", outs, exp_v); end
    endtask

    task automatic test_fault_recovery();
        logic [8:0] exp_v;
        pll_locked = 1'b1;
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        exp_v = 9'b0_0_0_0_0_0000; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL fr_restart: got %b want %b", outs, exp_v); end
        step(4);
        exp_v = 9'b1_0_0_0_0_0000; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL fr_release_f5: got %b want %b", outs, exp_v); end
        step(8);
        exp_v = 9'b1_0_0_0_0_0000; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL fr_f13: got %b want %b", outs, exp_v); end
        step(1);
        exp_v = 9'b1_1_1_0_0_0000; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL fr_run_f14: got %b want %b", outs, exp_v); end
    endtask

    // continues from RUN: reset together with restart, then a clean re-run
    task automatic test_reset_mid_run();
        logic [8:0] exp_v;
        reset_n = 1'b0;
        restart = 1'b1;
        step(1);
        reset_n = 1'b1;
        restart = 1'b0;
        exp_v = 9'b0_0_0_0_0_0000; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL mr_reset: got %b want %b", outs, exp_v); end
        step(12);
        exp_v = 9'b1_0_0_0_0_0000; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL mr_e12: got %b want %b", outs, exp_v); end
        step(1);
        exp_v = 9'b1_1_1_0_0_0000; vectors++;
        if (outs !== exp_v) begin miscompares++; $display("FAIL mr_run_e13: got %b want %b", outs, exp_v); end
    endtask

    initial begin
        reset_n    = 1'b0;
        restart    = 1'b0;
        pll_locked = 1'b0;
        test_reset();
        test_nominal();
        test_glitch();
        test_stable_vs_timeout();
        test_lock_loss();
        test_restart_vs_lock_loss();
        test_never_lock();
        test_fault_recovery();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
